// File: rtl/ucaspian_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ucaspian_pkg
// Description : Shared types and sizing helpers for the uCaspian synapse burst.
// Revision    : 1.0
// ============================================================================
package ucaspian_pkg;

    localparam int DEF_DEPTH       = 1024;
    localparam int DEF_WW          = 8;
    localparam int DEF_NW          = 8;
    localparam int DEF_LW          = 4;
    localparam int DEF_OFIFO_DEPTH = 4;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WALK = 1'b1
    } walk_state_t;

    typedef struct packed {
        logic                     en;
        logic signed [DEF_WW-1:0] weight;
        logic [DEF_NW-1:0]        target;
    } syn_entry_t;

    function automatic int calc_ew(input int ww, input int nw);
        return 1 + ww + nw;
    endfunction

    function automatic int calc_nbytes(input int ew);
        return (ew + 7) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ucaspian_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ucaspian_sync_fifo
// Description : Single-clock FIFO, head visible combinationally on pop_data_o.
// Revision    : 1.0
// ============================================================================
module ucaspian_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/ucaspian_synapse_burst.sv
`default_nettype none
// ============================================================================
// Module      : ucaspian_synapse_burst
// Description : Synapse table walked in bursts; enabled entries become dendrite fires.
// Revision    : 1.0
// ============================================================================
module ucaspian_synapse_burst
    import ucaspian_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int AW          = $clog2(DEPTH),
    parameter int WW          = DEF_WW,
    parameter int NW          = DEF_NW,
    parameter int LW          = DEF_LW,
    parameter int OFIFO_DEPTH = DEF_OFIFO_DEPTH,
    parameter int EW          = calc_ew(WW, NW),
    parameter int NBYTES      = calc_nbytes(EW),
    parameter int CBW         = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_act,
    input  logic          clear_config,
    output logic          clear_done,
    output logic          step_done,
    input  logic [AW-1:0] cfg_addr,
    input  logic [7:0]    cfg_value,
    input  logic [CBW-1:0] cfg_byte,
    input  logic          cfg_enable,
    input  logic [AW-1:0] syn_base,
    input  logic [LW-1:0] syn_len,
    input  logic          syn_vld,
    output logic          syn_rdy,
    output logic [NW-1:0] dend_addr,
    output logic [WW-1:0] dend_charge,
    output logic          dend_vld,
    input  logic          dend_rdy
);

    localparam int CW = $clog2(OFIFO_DEPTH) + 1;
    localparam int SW = (NBYTES > 1) ? (NBYTES - 1) * 8 : 8;
    localparam int FW = WW + NW;

    walk_state_t         state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [LW-1:0]       rem_q, rem_d;
    logic                w_flush;
    logic                w_accept;
    logic                w_rd_en;
    logic [CW-1:0]       w_occ;

    logic                rd_vld_q;
    logic [EW-1:0]       rd_data_q;
    logic [EW-1:0]       mem [DEPTH];

    logic [SW-1:0]       stage_q;
    logic [NBYTES*8-1:0] w_cfg_word;
    logic                w_cfg_last;
    logic                w_unused_cfg;
    logic                w_we;
    logic [AW-1:0]       w_waddr;
    logic [EW-1:0]       w_wdata;

    logic [AW-1:0]       clr_idx_q;
    logic                clr_fin_q;
    logic                w_clr_last;
    logic                clear_done_q;
    logic                step_done_q;

    logic                w_push;
    logic                w_pop;
    logic [FW-1:0]       w_head;
    logic [CW-1:0]       w_count;
    logic                w_unused_full;
    logic                w_empty;

    assign w_flush  = clear_act | clear_config;
    assign syn_rdy  = (state_q == S_IDLE) & ~reset & ~w_flush;
    assign w_accept = syn_vld & syn_rdy;
    // Reads already issued count against FIFO space so the FIFO can never overflow.
    assign w_occ    = w_count + CW'(rd_vld_q);

    // ---------------- walker FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_WALK;
                    ptr_d   = syn_base;
                    rem_d   = syn_len;
                end
            end
            S_WALK: begin
                if (w_flush) begin
                    state_d = S_IDLE;
                end else if (w_rd_en) begin
                    ptr_d = ptr_q + AW'(1);
                    rem_d = rem_q - LW'(1);
                    if (rem_q == '0) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_en = 1'b0;
        if (state_q == S_WALK && !w_flush && w_occ < CW'(OFIFO_DEPTH)) w_rd_en = 1'b1;
    end

    // ---------------- table ----------------
    always_ff @(posedge clk) begin
        if (reset) rd_vld_q <= 1'b0;
        else       rd_vld_q <= w_rd_en;
    end

    always_ff @(posedge clk) begin
        if (w_we)    mem[w_waddr] <= w_wdata;
        if (w_rd_en) rd_data_q    <= mem[ptr_q];
    end

    // ---------------- configuration ----------------
    always_comb begin
        w_cfg_word                      = '0;
        w_cfg_word[SW-1:0]              = stage_q;
        w_cfg_word[NBYTES*8-1 -: 8]     = cfg_value;
    end

    assign w_unused_cfg = ^w_cfg_word;
    assign w_cfg_last   = cfg_enable & ~clear_config & (cfg_byte == CBW'(NBYTES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else if (cfg_enable && !clear_config) begin
            for (int k = 0; k < NBYTES - 1; k++) begin
                if (cfg_byte == CBW'(k)) stage_q[8*k +: 8] <= cfg_value;
            end
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = cfg_addr;
        w_wdata = w_cfg_word[EW-1:0];
        if (reset) begin
            w_we = 1'b0;
        end else if (clear_config) begin
            if (!clr_fin_q) begin
                w_we    = 1'b1;
                w_waddr = clr_idx_q;
                w_wdata = '0;
            end
        end else if (w_cfg_last) begin
            w_we = 1'b1;
        end
    end

    // ---------------- table clear walker ----------------
    assign w_clr_last = clear_config & ~clr_fin_q & (clr_idx_q == AW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (reset || !clear_config) begin
            clr_idx_q <= '0;
            clr_fin_q <= 1'b0;
        end else if (!clr_fin_q) begin
            clr_idx_q <= clr_idx_q + AW'(1);
            if (w_clr_last) clr_fin_q <= 1'b1;
        end
    end

    // ---------------- status ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            clear_done_q <= 1'b0;
            step_done_q  <= 1'b0;
        end else begin
            clear_done_q <= clear_act | (clear_config & (clr_fin_q | w_clr_last));
            step_done_q  <= (state_q == S_IDLE) & ~syn_vld & ~rd_vld_q & w_empty;
        end
    end

    assign clear_done = clear_done_q;
    assign step_done  = step_done_q;

    // ---------------- output FIFO ----------------
    assign w_push = rd_vld_q & rd_data_q[EW-1] & ~w_flush;
    assign w_pop  = ~w_empty & dend_rdy;

    ucaspian_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (OFIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (w_flush),
        .push_i      (w_push),
        .push_data_i (rd_data_q[FW-1:0]),
        .pop_i       (w_pop),
        .pop_data_o  (w_head),
        .count_o     (w_count),
        .full_o      (w_unused_full),
        .empty_o     (w_empty)
    );

    assign dend_vld    = ~w_empty;
    assign dend_addr   = w_empty ? '0 : w_head[NW-1:0];
    assign dend_charge = w_empty ? '0 : w_head[FW-1:NW];

endmodule
`default_nettype wire

// File: tb/tb_ucaspian_synapse_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucaspian_synapse_burst
// Description : Directed self-checking bench for the synapse burst walker.
// Revision    : 1.0
// ============================================================================
module tb_ucaspian_synapse_burst;

    logic       clk = 1'b0;
    logic       reset, clear_act, clear_config, cfg_enable, syn_vld, dend_rdy;
    logic [9:0] cfg_addr, syn_base;
    logic [7:0] cfg_value;
    logic [1:0] cfg_byte;
    logic [3:0] syn_len;
    logic       clear_done, step_done, syn_rdy, dend_vld;
    logic [7:0] dend_addr, dend_charge;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int maxc   = 0;
    logic [7:0] got_t[$];
    logic [7:0] got_w[$];
    int         got_c[$];

    always #5 clk = ~clk;

    ucaspian_synapse_burst dut (
        .clk          (clk),
        .reset        (reset),
        .clear_act    (clear_act),
        .clear_config (clear_config),
        .clear_done   (clear_done),
        .step_done    (step_done),
        .cfg_addr     (cfg_addr),
        .cfg_value    (cfg_value),
        .cfg_byte     (cfg_byte),
        .cfg_enable   (cfg_enable),
        .syn_base     (syn_base),
        .syn_len      (syn_len),
        .syn_vld      (syn_vld),
        .syn_rdy      (syn_rdy),
        .dend_addr    (dend_addr),
        .dend_charge  (dend_charge),
        .dend_vld     (dend_vld),
        .dend_rdy     (dend_rdy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed handshake, away from the active edge.
    always @(negedge clk) begin
        if (dend_vld === 1'b1 && dend_rdy === 1'b1) begin
            got_t.push_back(dend_addr);
            got_w.push_back(dend_charge);
            got_c.push_back(cyc);
        end
        if (int'(dut.u_fifo.count_o) > maxc) maxc <= int'(dut.u_fifo.count_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_t.delete();
        got_w.delete();
        got_c.delete();
    endtask

    task automatic cfg_entry(input logic [9:0] a, input logic en, input logic [7:0] w,
                             input logic [7:0] t);
        logic [23:0] word;
        word = {7'd0, en, w, t};
        for (int l = 0; l < 3; l++) begin
            tick();
            cfg_enable = 1'b1;
            cfg_addr   = a;
            cfg_byte   = 2'(l);
            cfg_value  = word[8*l +: 8];
        end
        tick();
        cfg_enable = 1'b0;
    endtask

    task automatic fire(input logic [9:0] b, input logic [3:0] l);
        tick();
        syn_base = b;
        syn_len  = l;
        syn_vld  = 1'b1;
        tick();
        syn_vld  = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        do begin
            tick();
            @(negedge clk);
            n++;
        end while (step_done !== 1'b1 && n < bound);
        total++;
        if (step_done !== 1'b1) $display("FAIL idle_timeout: step_done=%b after %0d cycles, want 1", step_done, n);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_act = 1'b0; clear_config = 1'b0; cfg_enable = 1'b0;
        syn_vld = 1'b0; dend_rdy = 1'b1; cfg_addr = '0; syn_base = '0;
        cfg_value = '0; cfg_byte = '0; syn_len = '0;
        repeat (3) tick();
        @(negedge clk);
        total++; if (dend_vld !== 1'b0) $display("FAIL rst_vld: got %b want 0", dend_vld); else passed++;
        total++; if (dend_addr !== 8'h00) $display("FAIL rst_addr: got %h want 00", dend_addr); else passed++;
        total++; if (dend_charge !== 8'h00) $display("FAIL rst_charge: got %h want 00", dend_charge); else passed++;
        total++; if (clear_done !== 1'b0) $display("FAIL rst_clear_done: got %b want 0", clear_done); else passed++;
        total++; if (step_done !== 1'b0) $display("FAIL rst_step_done: got %b want 0", step_done); else passed++;
        total++; if (syn_rdy !== 1'b0) $display("FAIL rst_syn_rdy: got %b want 0", syn_rdy); else passed++;
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++; if (syn_rdy !== 1'b1) $display("FAIL rdy_after_rst: got %b want 1", syn_rdy); else passed++;
    endtask

    // Entry 5 = {en=1, w=-3, t=42}; first fire must appear three cycles after acceptance.
    task automatic test_single_fire();
        cfg_entry(10'd5, 1'b1, 8'hFD, 8'd42);
        clear_got();
        tick();
        syn_base = 10'd5; syn_len = 4'd0; syn_vld = 1'b1;
        @(negedge clk);
        total++; if (syn_rdy !== 1'b1) $display("FAIL t1_rdy: got %b want 1", syn_rdy); else passed++;
        for (int c = 1; c <= 3; c++) begin
            tick();
            syn_vld = 1'b0;
            @(negedge clk);
            total++;
            if (dend_vld !== (c == 3)) $display("FAIL t1_latency_c%0d: dend_vld=%b want %b", c, dend_vld, (c == 3));
            else passed++;
        end
        total++; if (dend_addr !== 8'd42) $display("FAIL t1_addr: got %0d want 42", dend_addr); else passed++;
        total++; if (dend_charge !== 8'hFD) $display("FAIL t1_charge: got %h want fd", dend_charge); else passed++;
        wait_idle(50);
        total++; if (got_t.size() != 1) $display("FAIL t1_count: got %0d want 1", got_t.size()); else passed++;
    endtask

    task automatic test_wrap_burst();
        logic [7:0] exp_t [8];
        logic [9:0] a;
        int         gap_err;
        exp_t = '{8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1, 8'd2, 8'd3};
        for (int i = 0; i < 8; i++) begin
            a = 10'(1020 + i);
            cfg_entry(a, 1'b1, a[7:0] ^ 8'h5A, a[7:0]);
        end
        dend_rdy = 1'b1;
        clear_got();
        fire(10'd1020, 4'd7);
        wait_idle(60);
        total++; if (got_t.size() != 8) $display("FAIL t2_count: got %0d want 8", got_t.size()); else passed++;
        gap_err = 0;
        for (int k = 0; k < 8 && k < got_t.size(); k++) begin
            total++;
            if (got_t[k] !== exp_t[k]) $display("FAIL t2_target_%0d: got %0d want %0d", k, got_t[k], exp_t[k]);
            else passed++;
            total++;
            if (got_w[k] !== (exp_t[k] ^ 8'h5A)) $display("FAIL t2_weight_%0d: got %h want %h", k, got_w[k], exp_t[k] ^ 8'h5A);
            else passed++;
            if (k > 0 && got_c[k] != got_c[k-1] + 1) gap_err++;
        end
        total++; if (gap_err != 0) $display("FAIL t2_back_to_back: gaps=%0d want 0", gap_err); else passed++;
    endtask

    task automatic test_stall();
        int bad, errs;
        for (int i = 16; i < 32; i++) cfg_entry(10'(i), 1'b1, 8'(i * 3), 8'(i));
        dend_rdy = 1'b0;
        clear_got();
        maxc = 0;
        fire(10'd16, 4'd15);
        bad = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            @(negedge clk);
            if (j >= 1 && (dend_vld !== 1'b1 || dend_addr !== 8'd16 || dend_charge !== 8'd48)) bad++;
        end
        total++; if (bad != 0) $display("FAIL t3_stall_hold: bad_cycles=%0d want 0", bad); else passed++;
        total++; if (got_t.size() != 0) $display("FAIL t3_no_fire_stalled: got %0d want 0", got_t.size()); else passed++;
        dend_rdy = 1'b1;
        wait_idle(80);
        total++; if (got_t.size() != 16) $display("FAIL t3_count: got %0d want 16", got_t.size()); else passed++;
        errs = 0;
        for (int k = 0; k < got_t.size(); k++) begin
            if (got_t[k] !== 8'(16 + k) || got_w[k] !== 8'((16 + k) * 3)) errs++;
        end
        total++; if (errs != 0) $display("FAIL t3_order: wrong_entries=%0d want 0", errs); else passed++;
        total++; if (maxc != 4) $display("FAIL t3_fifo_peak: got %0d want 4", maxc); else passed++;
    endtask

    task automatic test_sparse();
        for (int i = 0; i < 8; i++) cfg_entry(10'(i), (i % 2 == 0), 8'(i + 1), 8'(i));
        clear_got();
        fire(10'd0, 4'd7);
        wait_idle(60);
        total++; if (got_t.size() != 4) $display("FAIL t4_count: got %0d want 4", got_t.size()); else passed++;
        for (int k = 0; k < 4 && k < got_t.size(); k++) begin
            total++;
            if (got_t[k] !== 8'(2 * k) || got_w[k] !== 8'(2 * k + 1))
                $display("FAIL t4_fire_%0d: got t=%0d w=%0d want t=%0d w=%0d", k, got_t[k], got_w[k], 2 * k, 2 * k + 1);
            else passed++;
        end
    endtask

    task automatic test_clear_act();
        int errs;
        dend_rdy = 1'b1;
        clear_got();
        fire(10'd16, 4'd15);
        repeat (3) tick();
        tick();
        clear_act = 1'b1;
        @(negedge clk);
        total++; if (syn_rdy !== 1'b0) $display("FAIL t5_rdy_in_clear: got %b want 0", syn_rdy); else passed++;
        tick();
        @(negedge clk);
        total++; if (dend_vld !== 1'b0) $display("FAIL t5_vld_flushed: got %b want 0", dend_vld); else passed++;
        total++; if (clear_done !== 1'b1) $display("FAIL t5_clear_done: got %b want 1", clear_done); else passed++;
        tick();
        clear_act = 1'b0;
        @(negedge clk);
        total++; if (clear_done !== 1'b1) $display("FAIL t5_clear_done_held: got %b want 1", clear_done); else passed++;
        tick();
        @(negedge clk);
        total++; if (clear_done !== 1'b0) $display("FAIL t5_clear_done_drop: got %b want 0", clear_done); else passed++;
        total++; if (got_t.size() != 3) $display("FAIL t5_partial: got %0d want 3", got_t.size()); else passed++;
        repeat (10) tick();
        @(negedge clk);
        total++; if (got_t.size() != 3) $display("FAIL t5_no_stray: got %0d want 3", got_t.size()); else passed++;
        clear_got();
        fire(10'd16, 4'd3);
        wait_idle(40);
        total++; if (got_t.size() != 4) $display("FAIL t5_refire_count: got %0d want 4", got_t.size()); else passed++;
        errs = 0;
        for (int k = 0; k < got_t.size(); k++) begin
            if (got_t[k] !== 8'(16 + k) || got_w[k] !== 8'((16 + k) * 3)) errs++;
        end
        total++; if (errs != 0) $display("FAIL t5_refire_data: wrong_entries=%0d want 0", errs); else passed++;
    endtask

    task automatic test_reset_mid_burst();
        clear_got();
        fire(10'd16, 4'd15);
        repeat (3) tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        total++; if (syn_rdy !== 1'b0) $display("FAIL rmb_rdy: got %b want 0", syn_rdy); else passed++;
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++; if (dend_vld !== 1'b0) $display("FAIL rmb_vld: got %b want 0", dend_vld); else passed++;
        total++; if (dend_addr !== 8'h00 || dend_charge !== 8'h00)
            $display("FAIL rmb_data: got addr=%h charge=%h want 00/00", dend_addr, dend_charge);
        else passed++;
        total++; if (step_done !== 1'b0) $display("FAIL rmb_step_done: got %b want 0", step_done); else passed++;
        repeat (10) tick();
        @(negedge clk);
        total++; if (got_t.size() != 3) $display("FAIL rmb_abandoned: got %0d want 3", got_t.size()); else passed++;
    endtask

    // Table clear takes one write per entry; clear_done shows up in cycle DEPTH.
    task automatic test_clear_config();
        int n;
        clear_got();
        tick();
        clear_config = 1'b1;
        n = 0;
        do begin
            tick();
            @(negedge clk);
            n++;
            if (n == 1) begin
                total++; if (syn_rdy !== 1'b0) $display("FAIL t6_rdy_in_clear: got %b want 0", syn_rdy); else passed++;
            end
        end while (clear_done !== 1'b1 && n < 1100);
        total++; if (n != 1024) $display("FAIL t6_clear_time: got %0d cycles want 1024", n); else passed++;
        cfg_entry(10'd16, 1'b1, 8'h11, 8'd16);
        @(negedge clk);
        total++; if (clear_done !== 1'b1) $display("FAIL t6_clear_done_held: got %b want 1", clear_done); else passed++;
        tick();
        clear_config = 1'b0;
        tick();
        @(negedge clk);
        total++; if (clear_done !== 1'b0) $display("FAIL t6_clear_done_drop: got %b want 0", clear_done); else passed++;
        fire(10'd16, 4'd15);
        wait_idle(60);
        fire(10'd1020, 4'd7);
        wait_idle(60);
        fire(10'd0, 4'd7);
        wait_idle(60);
        total++; if (got_t.size() != 0) $display("FAIL t6_no_fires: got %0d want 0", got_t.size()); else passed++;
        total++; if (step_done !== 1'b1) $display("FAIL t6_step_done: got %b want 1", step_done); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_fire();
        test_wrap_burst();
        test_stall();
        test_sparse();
        test_clear_act();
        test_reset_mid_burst();
        test_clear_config();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
`default_nettype wire
